// File: rtl/det_pkg.sv
// Shared constants, state encoding and index helpers for the determinant
// engine front-end loader.
package det_pkg;

    localparam int N  = 8;               // matrix dimension
    localparam int W  = 32;              // element / result width
    localparam int CW = 24;              // cycle-counter width
    localparam int NN = N * N;           // elements per job
    localparam int IW = $clog2(NN);      // element index width
    localparam int RW = $clog2(N);       // row / column index width

    // One-hot loader state encoding
    localparam logic [4:0] S_FILL    = 5'b00001;
    localparam logic [4:0] S_LAUNCH  = 5'b00010;
    localparam logic [4:0] S_WAIT    = 5'b00100;
    localparam logic [4:0] S_RESULT  = 5'b01000;
    localparam logic [4:0] S_RELEASE = 5'b10000;

    typedef enum logic [4:0] {
        ST_FILL    = S_FILL,
        ST_LAUNCH  = S_LAUNCH,
        ST_WAIT    = S_WAIT,
        ST_RESULT  = S_RESULT,
        ST_RELEASE = S_RELEASE
    } state_t;

    typedef struct packed {
        logic [RW-1:0] r;
        logic [RW-1:0] c;
    } rc_t;

    // Row-major element index to (row, column). N is a power of two, so the
    // index splits cleanly into a row field above a column field.
    function automatic rc_t idx_to_rc(input logic [IW-1:0] idx);
        rc_t rc;
        rc.r = idx[IW-1:RW];
        rc.c = idx[RW-1:0];
        return rc;
    endfunction

endpackage

// File: rtl/det_mat_regfile.sv
// N*N x W matrix register file: one synchronous write port addressed by a
// row-major element index, async reset to zero, flattened parallel read bus.
module det_mat_regfile
    import det_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_we,
    input  logic [IW-1:0]    i_idx,
    input  logic [W-1:0]     i_data,
    output logic [NN*W-1:0]  o_mat
);

    rc_t          w_rc;
    logic [W-1:0] r_mem [N][N];

    assign w_rc = idx_to_rc(i_idx);

    // Element storage: cleared on reset, one element written per accepted beat.
    // NOTE: this storage is reset deliberately: the engine sees Mat directly
    // and an all-zero matrix is its defined idle value, so it is built from
    // flops rather than an unreset RAM.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_mem[r][c] <= '0;
                end
            end
        end else if (i_we) begin
            r_mem[w_rc.r][w_rc.c] <= i_data;
        end
    end

    // Element (r,c) sits at bits [(r*N+c)*W +: W] of the flattened bus.
    genvar gr, gc;
    generate
        for (gr = 0; gr < N; gr++) begin : g_row
            for (gc = 0; gc < N; gc++) begin : g_col
                assign o_mat[(gr*N+gc)*W +: W] = r_mem[gr][gc];
            end
        end
    endgenerate

endmodule

// File: rtl/det_matrix_loader.sv
// Front-end feeder for the 8x8 determinant engine: collects a row-major
// element stream, launches the engine, captures the determinant with a
// Start-to-Done cycle count and hands it out on a valid/ready result port.
module det_matrix_loader
    import det_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             In_Valid,
    input  logic [W-1:0]     In_Data,
    output logic             In_Ready,
    output logic [NN*W-1:0]  Mat,
    output logic             Start,
    output logic             Ack,
    input  logic             Eng_Done,
    input  logic [W-1:0]     Det_In,
    output logic             Res_Valid,
    output logic [W-1:0]     Res_Data,
    output logic [CW-1:0]    Res_Cycles,
    input  logic             Res_Ready,
    output logic             Busy
);

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_res_data;
    logic [CW-1:0] r_res_cycles;

    logic          w_accept;
    logic [CW-1:0] w_cnt_inc;

    // Outputs decode from the registered one-hot state only.
    assign In_Ready   = (r_state == ST_FILL);
    assign Start      = (r_state == ST_LAUNCH);
    assign Res_Valid  = (r_state == ST_RESULT);
    assign Ack        = (r_state == ST_RELEASE);
    assign Busy       = (r_state != ST_FILL);
    assign Res_Data   = r_res_data;
    assign Res_Cycles = r_res_cycles;

    // A beat is only ever taken in FILL, so Mat cannot move while a job runs.
    assign w_accept  = In_Valid && In_Ready;

    // Counter value including the current WAIT cycle, held at all-ones.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    det_mat_regfile u_regfile (
        .Clk    (Clk),
        .Reset  (Reset),
        .i_we   (w_accept),
        .i_idx  (r_idx),
        .i_data (In_Data),
        .o_mat  (Mat)
    );

    // Job sequencing FSM with fill index, cycle counter and result capture.
    // NOTE: all state here uses non-blocking assignments so every register
    // in the block updates from the same pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_FILL;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_res_data   <= '0;
            r_res_cycles <= '0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        if (r_idx == IW'(NN - 1)) begin
                            r_idx   <= '0;
                            r_state <= ST_LAUNCH;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (Eng_Done) begin
                        r_res_data   <= Det_In;
                        r_res_cycles <= w_cnt_inc;
                        r_state      <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (Res_Ready) begin
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!Eng_Done) begin
                        r_state <= ST_FILL;
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_det_matrix_loader.sv
// Directed self-checking bench for det_matrix_loader with a behavioural
// determinant engine that computes the determinant of the presented matrix.
module tb_det_matrix_loader;
    import det_pkg::*;

    localparam int MB = NN * W;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          In_Valid;
    logic [W-1:0]  In_Data;
    logic          In_Ready;
    logic [MB-1:0] Mat;
    logic          Start;
    logic          Ack;
    logic          Eng_Done;
    logic [W-1:0]  Det_In;
    logic          Res_Valid;
    logic [W-1:0]  Res_Data;
    logic [CW-1:0] Res_Cycles;
    logic          Res_Ready;
    logic          Busy;

    int checks   = 0;
    int failures = 0;
    int start_pulses = 0;

    // Engine model controls
    int           eng_lat = 4;
    bit           eng_fixed = 1'b0;
    logic [W-1:0] eng_fixed_val = '0;
    int           eng_cnt = 0;
    bit           eng_run = 1'b0;

    always #5 Clk = ~Clk;

    det_matrix_loader dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .In_Valid   (In_Valid),
        .In_Data    (In_Data),
        .In_Ready   (In_Ready),
        .Mat        (Mat),
        .Start      (Start),
        .Ack        (Ack),
        .Eng_Done   (Eng_Done),
        .Det_In     (Det_In),
        .Res_Valid  (Res_Valid),
        .Res_Data   (Res_Data),
        .Res_Cycles (Res_Cycles),
        .Res_Ready  (Res_Ready),
        .Busy       (Busy)
    );

    // Fraction-free (Bareiss) determinant with row pivoting, truncated to W bits.
    function automatic logic [W-1:0] golden_det(input logic [MB-1:0] m);
        longint a [N][N];
        longint prev;
        longint t;
        int     sgn;
        int     p;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                a[r][c] = longint'($signed(m[(r*N+c)*W +: W]));
        sgn  = 1;
        prev = 1;
        for (int k = 0; k < N - 1; k++) begin
            if (a[k][k] == 0) begin
                p = -1;
                for (int i = k + 1; i < N; i++)
                    if (p < 0 && a[i][k] != 0) p = i;
                if (p < 0) return '0;
                for (int j = 0; j < N; j++) begin
                    t = a[k][j]; a[k][j] = a[p][j]; a[p][j] = t;
                end
                sgn = -sgn;
            end
            for (int i = k + 1; i < N; i++)
                for (int j = k + 1; j < N; j++)
                    a[i][j] = (a[i][j] * a[k][k] - a[i][k] * a[k][j]) / prev;
            prev = a[k][k];
        end
        t = longint'(sgn) * a[N-1][N-1];
        return t[W-1:0];
    endfunction

    // Behavioural engine: Done eng_lat cycles after Start, held until Ack seen.
    always @(negedge Clk) begin
        if (Reset) begin
            Eng_Done = 1'b0;
            Det_In   = '0;
            eng_run  = 1'b0;
        end else begin
            if (Eng_Done && Ack) Eng_Done = 1'b0;
            if (Start) begin
                eng_run = 1'b1;
                eng_cnt = eng_lat;
            end else if (eng_run) begin
                eng_cnt--;
                if (eng_cnt <= 0) begin
                    eng_run  = 1'b0;
                    Eng_Done = 1'b1;
                    Det_In   = eng_fixed ? eng_fixed_val : golden_det(Mat);
                end
            end
        end
    end

    // Start pulse monitor.
    always @(negedge Clk) if (!Reset && Start) start_pulses++;

    // Matrix builders
    function automatic logic [MB-1:0] diag_mat(input logic [W-1:0] v);
        logic [MB-1:0] m = '0;
        for (int i = 0; i < N; i++) m[(i*N+i)*W +: W] = v;
        return m;
    endfunction

    function automatic logic [MB-1:0] swap_mat();
        logic [MB-1:0] m = diag_mat(32'd1);
        m[(0*N+0)*W +: W] = '0;
        m[(1*N+1)*W +: W] = '0;
        m[(0*N+1)*W +: W] = 32'd1;
        m[(1*N+0)*W +: W] = 32'd1;
        return m;
    endfunction

    function automatic logic [MB-1:0] zero_row_mat();
        logic [MB-1:0] m = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (r != 3) m[(r*N+c)*W +: W] = W'($urandom_range(0, 6)) - 32'd3;
        return m;
    endfunction

    // Upper triangular, diagonal 1..8: determinant 8! = 40320.
    function automatic logic [MB-1:0] tri_mat();
        logic [MB-1:0] m = '0;
        for (int r = 0; r < N; r++)
            for (int c = r; c < N; c++)
                m[(r*N+c)*W +: W] = (c == r) ? W'(r + 1) : W'($urandom_range(0, 5));
        return m;
    endfunction

    // Stream a matrix row-major; on return we are at the negedge of LAUNCH.
    task automatic fill(input logic [MB-1:0] m, input bit gaps);
        int g;
        for (int i = 0; i < NN; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    In_Valid = 1'b0;
                    @(negedge Clk);
                end
            end
            In_Valid = 1'b1;
            In_Data  = m[i*W +: W];
            @(negedge Clk);
        end
        In_Valid = 1'b0;
    endtask

    task automatic wait_valid(input int max, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < max; i++) begin
            if (Res_Valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
            n++;
        end
    endtask

    task automatic wait_fill(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (In_Ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
    endtask

    // Full job with consumer always ready: fill, launch, result, release.
    task automatic run_job(input string name, input logic [MB-1:0] m,
                           input logic [W-1:0] exp_det, input bit gaps);
        int s0;
        int n;
        bit ok;
        s0 = start_pulses;
        Res_Ready = 1'b1;
        fill(m, gaps);
        checks++;
        if (Start !== 1'b1 || In_Ready !== 1'b0 || Busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_launch: Start=%b In_Ready=%b Busy=%b, required 1 0 1",
                     name, Start, In_Ready, Busy);
        end
        wait_valid(200, ok, n);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_valid_timeout: Res_Valid=%b, required 1", name, Res_Valid);
        end
        checks++;
        if (n !== eng_lat + 1) begin
            failures++;
            $display("FAIL %s_latency: Res_Valid %0d cycles after Start, required %0d",
                     name, n, eng_lat + 1);
        end
        checks++;
        if (Res_Data !== exp_det) begin
            failures++;
            $display("FAIL %s_det: got %h, required %h", name, Res_Data, exp_det);
        end
        checks++;
        if (Res_Cycles !== CW'(eng_lat)) begin
            failures++;
            $display("FAIL %s_cycles: got %0d, required %0d", name, Res_Cycles, eng_lat);
        end
        checks++;
        if (Mat !== m) begin
            failures++;
            $display("FAIL %s_mat_stable: Mat differs from filled matrix", name);
        end
        wait_fill(50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_return_timeout: In_Ready=%b, required 1", name, In_Ready);
        end
        checks++;
        if (start_pulses - s0 !== 1) begin
            failures++;
            $display("FAIL %s_start_count: got %0d pulses, required 1", name, start_pulses - s0);
        end
        Res_Ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        In_Valid = 1'b1;
        In_Data = 32'h0000_0055;
        Res_Ready = 1'b1;
        repeat (3) @(negedge Clk);
        checks++;
        if (In_Ready !== 1'b1 || Start !== 1'b0 || Ack !== 1'b0 ||
            Res_Valid !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: In_Ready=%b Start=%b Ack=%b Res_Valid=%b Busy=%b, required 1 0 0 0 0",
                     In_Ready, Start, Ack, Res_Valid, Busy);
        end
        checks++;
        if (Res_Data !== '0 || Res_Cycles !== '0) begin
            failures++;
            $display("FAIL reset_result: Res_Data=%h Res_Cycles=%h, required 0 0", Res_Data, Res_Cycles);
        end
        In_Valid = 1'b0;
        Res_Ready = 1'b0;
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (Mat !== '0) begin
            failures++;
            $display("FAIL reset_mat: Mat nonzero after reset with In_Valid high, required 0");
        end
    endtask

    task automatic test_identity();
        logic [MB-1:0] m;
        m = diag_mat(32'd1);
        run_job("identity", m, 32'd1, 1'b0);
        checks++;
        if (Mat[0 +: W] !== 32'd1 || Mat[(N*N-1)*W +: W] !== 32'd1 || Mat[1*W +: W] !== 32'd0) begin
            failures++;
            $display("FAIL identity_diag: m00=%h m77=%h m01=%h, required 1 1 0",
                     Mat[0 +: W], Mat[(N*N-1)*W +: W], Mat[1*W +: W]);
        end
    endtask

    task automatic test_back_to_back();
        run_job("diag2", diag_mat(32'd2), 32'd256, 1'b0);
        run_job("swap", swap_mat(), 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_zero_row();
        run_job("zero_row", zero_row_mat(), 32'd0, 1'b0);
    endtask

    task automatic test_slow_consumer();
        logic [MB-1:0] m;
        int n;
        bit ok;
        m = diag_mat(32'd3);
        eng_lat = 5;
        eng_fixed = 1'b1;
        eng_fixed_val = 32'h0000_1234;
        Res_Ready = 1'b0;
        fill(m, 1'b0);
        wait_valid(100, ok, n);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL slow_valid_timeout: Res_Valid=%b, required 1", Res_Valid);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (Res_Valid !== 1'b1 || Res_Data !== 32'h0000_1234 || Res_Cycles !== 24'd5) begin
                failures++;
                $display("FAIL slow_hold_%0d: valid=%b data=%h cycles=%0d, required 1 00001234 5",
                         i, Res_Valid, Res_Data, Res_Cycles);
            end
            checks++;
            if (Ack !== 1'b0 || In_Ready !== 1'b0) begin
                failures++;
                $display("FAIL slow_ack_%0d: Ack=%b In_Ready=%b, required 0 0", i, Ack, In_Ready);
            end
            checks++;
            if (Mat !== m) begin
                failures++;
                $display("FAIL slow_mat_%0d: Mat changed while busy", i);
            end
            In_Valid = (i % 2 == 0);
            In_Data  = 32'hDEAD_BEEF;
            @(negedge Clk);
        end
        In_Valid = 1'b0;
        Res_Ready = 1'b1;
        @(negedge Clk);
        Res_Ready = 1'b0;
        checks++;
        if (Ack !== 1'b1 || Res_Valid !== 1'b0) begin
            failures++;
            $display("FAIL slow_release: Ack=%b Res_Valid=%b, required 1 0", Ack, Res_Valid);
        end
        @(negedge Clk);
        checks++;
        if (In_Ready !== 1'b1 || Ack !== 1'b0 || Mat !== m) begin
            failures++;
            $display("FAIL slow_return: In_Ready=%b Ack=%b mat_ok=%b, required 1 0 1",
                     In_Ready, Ack, Mat === m);
        end
        eng_fixed = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        eng_lat = 40;
        Res_Ready = 1'b1;
        fill(diag_mat(32'd5), 1'b0);
        repeat (5) @(negedge Clk);
        checks++;
        if (Busy !== 1'b1 || In_Ready !== 1'b0 || Res_Valid !== 1'b0) begin
            failures++;
            $display("FAIL midwait_busy: Busy=%b In_Ready=%b Res_Valid=%b, required 1 0 0",
                     Busy, In_Ready, Res_Valid);
        end
        Reset = 1'b1;
        In_Valid = 1'b1;
        In_Data = 32'h0000_0077;
        #1;
        checks++;
        if (In_Ready !== 1'b1 || Start !== 1'b0 || Ack !== 1'b0 ||
            Res_Valid !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL midwait_reset_ctrl: In_Ready=%b Start=%b Ack=%b Res_Valid=%b Busy=%b, required 1 0 0 0 0",
                     In_Ready, Start, Ack, Res_Valid, Busy);
        end
        checks++;
        if (Mat !== '0 || Res_Data !== '0 || Res_Cycles !== '0) begin
            failures++;
            $display("FAIL midwait_reset_regs: mat_zero=%b Res_Data=%h Res_Cycles=%h, required 1 0 0",
                     Mat === '0, Res_Data, Res_Cycles);
        end
        repeat (2) @(negedge Clk);
        In_Valid = 1'b0;
        Reset = 1'b0;
        Res_Ready = 1'b0;
        eng_lat = 3;
        run_job("after_reset", tri_mat(), 32'd40320, 1'b1);
    endtask

    // Watchdog: a hung run still reports.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        In_Valid = 1'b0;
        In_Data = '0;
        Res_Ready = 1'b0;
        @(negedge Clk);
        test_reset();
        test_identity();
        test_back_to_back();
        test_zero_row();
        test_slow_consumer();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
